// File: rtl/cereal_pkg.sv
//------------------------------------------------------------------------------
//  Module   : cereal_pkg
//  Brief    : Shared frame constants, bit timing default and receiver FSM
//             state encoding for the cereal serial blocks.
//  Options  : CEREAL_RX_PARITY_EN adds the PARITY state encoding.
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cereal_pkg;

  // Bit timing shared with the transmitter and the board clock dividers
  // (9600 baud from a 50 MHz system clock).
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  // Frame shape
  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Receiver FSM state encoding
  typedef logic [2:0] rx_state_t;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef CEREAL_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

endpackage

`default_nettype wire

// File: rtl/sync2.sv
//------------------------------------------------------------------------------
//  Module   : sync2
//  Brief    : Two-flop synchroniser for asynchronous single-bit inputs
//             (serial line, switches, buttons) with a selectable reset value.
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; the first stage may go metastable, the second settles.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/cereal_rx.sv
//------------------------------------------------------------------------------
//  Module   : cereal_rx
//  Brief    : 8N1 serial receiver. Oversamples the line, samples each bit at
//             its midpoint and presents bytes on a valid/ready interface with
//             framing and overrun error pulses.
//  Options  : CEREAL_RX_PARITY_EN switches to 8E1 framing and adds parity_err.
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cereal_rx
  import cereal_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
`ifdef CEREAL_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [2:0]    c_IDX_LAST  = 3'(DATA_BITS - 1);

  logic w_rx_s;

  rx_state_t      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           fe_q, fe_d;
  logic           ov_q, ov_d;
`ifdef CEREAL_RX_PARITY_EN
  logic           pe_q, pe_d;
  logic           par_bad_q, par_bad_d;
`endif

  // Line idles high, so the synchroniser resets to the idle level to avoid
  // a false start bit out of reset.
  sync2 #(
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk_i   (sysclk),
    .rst_n_i (rst_n),
    .d_i     (rx),
    .q_o     (w_rx_s)
  );

  // Next-state logic: bit timing, shifting and output handoff.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
`ifdef CEREAL_RX_PARITY_EN
    pe_d      = 1'b0;
    par_bad_d = par_bad_q;
`endif

    // Accepted byte frees the output; a byte completing this same cycle
    // may overwrite this below.
    if (valid_q && ready) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!w_rx_s) state_d = ST_START;
      end

      ST_START: begin
        if (cnt_q == c_HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A line that is high again at mid-start was only a glitch.
          state_d = w_rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == c_BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {w_rx_s, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == c_IDX_LAST) begin
`ifdef CEREAL_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef CEREAL_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == c_BIT_LAST) begin
          cnt_d     = '0;
          // Even parity: data bits plus parity bit must XOR to zero.
          par_bad_d = (^shift_q) ^ w_rx_s;
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      ST_STOP: begin
        if (cnt_q == c_BIT_LAST) begin
          cnt_d   = '0;
          // Back to IDLE on the sample edge so a following start bit
          // with no idle gap is still caught.
          state_d = ST_IDLE;
          if (w_rx_s != STOP_LEVEL) begin
            fe_d = 1'b1;
`ifdef CEREAL_RX_PARITY_EN
          end else if (par_bad_q) begin
            pe_d = 1'b1;
`endif
          end else if (!valid_q || ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ov_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
`ifdef CEREAL_RX_PARITY_EN
      pe_q      <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
`ifdef CEREAL_RX_PARITY_EN
      pe_q      <= pe_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef CEREAL_RX_PARITY_EN
  assign parity_err = pe_q;
`endif

endmodule

`default_nettype wire
